// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared async-FIFO constants and Gray/binary pointer conversions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int FIFO_ADDRSIZE = 4;
    localparam int DEPTH         = 2 ** FIFO_ADDRSIZE;

    // Conversions run on a wide vector; callers zero-extend and slice back to
    // their own pointer width, so any ADDRSIZE up to 31 is served.
    localparam int PTR_MAXW      = 32;

    function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] gray);
        logic [PTR_MAXW-1:0] bin;
        bin[PTR_MAXW-1] = gray[PTR_MAXW-1];
        for (int i = PTR_MAXW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
// ============================================================================
// Module   : wptr_full_ctrl
// Purpose  : Write-side pointer, full/almost-full, level and overflow control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = FIFO_ADDRSIZE,
    parameter int AFULL_THRESH = (2 ** ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int                c_ptr_w        = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] c_afull_thresh = AFULL_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0]   r_wbin;
    logic [ADDRSIZE:0]   w_wbinnext;
    logic [ADDRSIZE:0]   w_wgraynext;
    logic [ADDRSIZE:0]   w_rbin_s;
    logic [ADDRSIZE:0]   w_wlevel_next;
    logic                w_winc_ok;
    logic                w_wfull_val;
    logic [PTR_MAXW-1:0] w_gray_wide;
    logic [PTR_MAXW-1:0] w_rbin_wide;
    logic                w_unused;

    assign w_winc_ok   = winc & ~wfull;
    assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_winc_ok};

    assign w_gray_wide = bin2gray({{(PTR_MAXW-c_ptr_w){1'b0}}, w_wbinnext});
    assign w_rbin_wide = gray2bin({{(PTR_MAXW-c_ptr_w){1'b0}}, wq2_rptr});
    assign w_wgraynext = w_gray_wide[ADDRSIZE:0];
    assign w_rbin_s    = w_rbin_wide[ADDRSIZE:0];
    assign w_unused    = &{1'b0, w_gray_wide[PTR_MAXW-1:c_ptr_w], w_rbin_wide[PTR_MAXW-1:c_ptr_w]};

    // Full when the next write pointer sits exactly one lap ahead of the
    // synchronized read pointer: top two Gray bits inverted, the rest equal.
    assign w_wfull_val   = (w_wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    assign w_wlevel_next = w_wbinnext - w_rbin_s;

    assign waddr = r_wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin <= '0;
            wptr   <= '0;
        end else begin
            r_wbin <= w_wbinnext;
            wptr   <= w_wgraynext;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wlevel <= '0;
        end else begin
            wfull  <= w_wfull_val;
            wafull <= (w_wlevel_next >= c_afull_thresh);
            wlevel <= w_wlevel_next;
        end
    end

    // A new overflow outranks a clear arriving on the same edge.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wovf <= 1'b0;
        end else begin
            wovf <= (winc & wfull) | (wovf & ~wovf_clr);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
// ============================================================================
// Module   : tb_wptr_full_ctrl
// Purpose  : Scoreboarded self-checking bench for wptr_full_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wptr_full_ctrl;

    localparam int ADDRSIZE     = 4;
    localparam int AFULL_THRESH = 14;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wovf_clr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wlevel;
    logic       wovf;

    wptr_full_ctrl #(
        .ADDRSIZE    (ADDRSIZE),
        .AFULL_THRESH(AFULL_THRESH)
    ) u_dut (
        .wclk    (wclk),
        .wrst_n  (wrst_n),
        .winc    (winc),
        .wq2_rptr(wq2_rptr),
        .wovf_clr(wovf_clr),
        .waddr   (waddr),
        .wptr    (wptr),
        .wfull   (wfull),
        .wafull  (wafull),
        .wlevel  (wlevel),
        .wovf    (wovf)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic [4:0] wptr;
        logic [3:0] waddr;
        logic       wfull;
        logic       wafull;
        logic [4:0] wlevel;
        logic       wovf;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: writes counted in binary, occupancy from the reader.
    logic [4:0] m_wbin;
    logic [4:0] m_level;
    logic       m_full;
    logic       m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [4:0] m_b2g(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    function automatic logic [4:0] m_g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic model_reset();
        m_wbin  = '0;
        m_level = '0;
        m_full  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic step(input logic i_inc, input logic [4:0] i_rgray, input logic i_clr);
        exp_t e;
        exp_t got;
        logic ok;
        @(negedge wclk);
        winc     = i_inc;
        wq2_rptr = i_rgray;
        wovf_clr = i_clr;
        ok       = i_inc & ~m_full;
        m_ovf    = (i_inc & m_full) | (m_ovf & ~i_clr);
        m_wbin   = m_wbin + {4'd0, ok};
        m_level  = m_wbin - m_g2b(i_rgray);
        m_full   = (m_level == 5'd16);
        e.wptr   = m_b2g(m_wbin);
        e.waddr  = m_wbin[3:0];
        e.wfull  = m_full;
        e.wafull = (m_level >= 5'd14);
        e.wlevel = m_level;
        e.wovf   = m_ovf;
        sb.push_back(e);
        @(posedge wclk);
        #1;
        e   = sb.pop_front();
        got = '{wptr: wptr, waddr: waddr, wfull: wfull, wafull: wafull, wlevel: wlevel, wovf: wovf};
        check("sb_wptr",   32'(got.wptr),   32'(e.wptr));
        check("sb_waddr",  32'(got.waddr),  32'(e.waddr));
        check("sb_wfull",  32'(got.wfull),  32'(e.wfull));
        check("sb_wafull", 32'(got.wafull), 32'(e.wafull));
        check("sb_wlevel", 32'(got.wlevel), 32'(e.wlevel));
        check("sb_wovf",   32'(got.wovf),   32'(e.wovf));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wptr"},   32'(wptr),   32'd0);
        check({tag, "_waddr"},  32'(waddr),  32'd0);
        check({tag, "_wfull"},  32'(wfull),  32'd0);
        check({tag, "_wafull"}, 32'(wafull), 32'd0);
        check({tag, "_wlevel"}, 32'(wlevel), 32'd0);
        check({tag, "_wovf"},   32'(wovf),   32'd0);
    endtask

    // Reset asserted between edges, checked before the next edge arrives.
    task automatic async_reset(input string tag);
        #1 wrst_n = 1'b0;
        winc      = 1'b0;
        wq2_rptr  = '0;
        wovf_clr  = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wq2_rptr = '0;
        wovf_clr = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge wclk);
        wrst_n = 1'b1;

        // Fill from empty with the reader parked at 0.
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 5'd0, 1'b0);
            check("fill_level", 32'(wlevel), 32'(k));
            if (k == 13) check("afull_13", 32'(wafull), 32'd0);
            if (k == 14) check("afull_14", 32'(wafull), 32'd1);
            if (k == 15) check("full_15",  32'(wfull),  32'd0);
        end
        check("full_16",  32'(wfull), 32'd1);
        check("wptr_16",  32'(wptr),  32'h18);
        check("waddr_16", 32'(waddr), 32'd0);

        // Writes while full are dropped and flagged.
        for (int k = 0; k < 3; k++) step(1'b1, 5'd0, 1'b0);
        check("ovf_hold_wptr",  32'(wptr),   32'h18);
        check("ovf_hold_level", 32'(wlevel), 32'd16);
        check("ovf_set",        32'(wovf),   32'd1);
        step(1'b0, 5'd0, 1'b1);
        check("ovf_clr", 32'(wovf), 32'd0);
        step(1'b1, 5'd0, 1'b1);
        check("ovf_set_wins", 32'(wovf), 32'd1);

        // Reader frees one slot, then one more write refills it.
        step(1'b0, 5'b00001, 1'b0);
        check("rd1_full",  32'(wfull),  32'd0);
        check("rd1_level", 32'(wlevel), 32'd15);
        check("rd1_afull", 32'(wafull), 32'd1);
        step(1'b1, 5'b00001, 1'b0);
        check("refill_full",  32'(wfull), 32'd1);
        check("refill_wptr",  32'(wptr),  32'h19);
        check("refill_waddr", 32'(waddr), 32'd1);

        async_reset("async_rst");

        // Simultaneous write and read at level 10.
        for (int k = 0; k < 10; k++) step(1'b1, 5'd0, 1'b0);
        check("lvl10_pre", 32'(wlevel), 32'd10);
        step(1'b1, m_b2g(5'd1), 1'b0);
        check("lvl10_level", 32'(wlevel), 32'd10);
        check("lvl10_full",  32'(wfull),  32'd0);

        async_reset("async_rst2");

        // Wrap-around with the reader trailing two counts behind.
        for (int k = 0; k < 40; k++) begin
            logic [4:0] rb;
            rb = (k == 0) ? 5'd0 : 5'(k - 1);
            step(1'b1, m_b2g(rb), 1'b0);
            check("wrap_level_le2", 32'(wlevel <= 5'd2), 32'd1);
            if (k == 31) check("wrap_wptr_zero", 32'(wptr), 32'd0);
        end
        check("wrap_no_full", 32'(wfull), 32'd0);
        check("wrap_waddr",   32'(waddr), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-domain pointer and status controller for the async FIFO. It is the write-side counterpart of the read-pointer/empty logic. It keeps the binary write counter and publishes the Gray write pointer for synchronization into the read domain. It produces the registered full and almost-full flags, a fill level, and a sticky overflow flag, using the read pointer after it has been synchronized into wclk (wq2_rptr).

Parameters:
ADDRSIZE, 4, memory address width; FIFO depth = 2**ADDRSIZE; legal range ADDRSIZE >= 2
AFULL_THRESH, 2**ADDRSIZE - 2, fill level at or above which wafull asserts; legal range 1..2**ADDRSIZE

Ports:
wclk  input  1  write-domain clock; all state updates on the rising edge
wrst_n  input  1  asynchronous, active-low reset
winc  input  1  write request; honored only when wfull=0
wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already 2-flop synchronized into wclk
wovf_clr  input  1  synchronous clear of the sticky overflow flag
waddr  output  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0]
wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchronizer
wfull  output  1  registered full flag
wafull  output  1  registered almost-full flag
wlevel  output  ADDRSIZE+1  registered fill level, 0..2**ADDRSIZE
wovf  output  1  sticky flag: a write was attempted while full

Behaviour:
- Reset (wrst_n=0, asynchronous, no clock needed):
  - wbin=0, wptr=0, waddr=0.
  - wfull=0, wafull=0 (0 also when AFULL_THRESH=... any legal value >0), wlevel=0, wovf=0.
- Internal binary counter wbin, width ADDRSIZE+1.
- winc_ok = winc & ~wfull.
- wbinnext = wbin + winc_ok, modulo 2**(ADDRSIZE+1); wraps silently.
- wgraynext = (wbinnext >> 1) ^ wbinnext.
- wbin and wptr register wbinnext and wgraynext on every wclk edge; zero-latency address.
  - waddr presented in cycle N is the slot written by a winc_ok in cycle N.
- Full compare:
  - wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull <= wfull_val, so it asserts on the same edge that commits the last free slot.
- Fill level:
  - rbin_s = gray-to-binary of wq2_rptr (combinational, XOR prefix from MSB).
  - wlevel_next = (wbinnext - rbin_s) mod 2**(ADDRSIZE+1).
  - wlevel <= wlevel_next.
  - wafull <= (wlevel_next >= AFULL_THRESH).
  - All three flags (wfull, wafull, wlevel) update on the same edge and stay mutually consistent.
- Pessimism: wq2_rptr lags the true read pointer by the synchronizer latency.
  - wfull, wafull and wlevel may overstate occupancy but never understate it.
  - wfull deasserts only on the edge after wq2_rptr changes.
- Overflow:
  - wovf sets on an edge where winc & wfull.
  - It clears on an edge where wovf_clr=1 and no new overflow occurs.
  - A set in the same cycle as a clear wins (wovf stays 1).
- Write while full: wbin, wptr and waddr hold; memory write enable must be driven from winc_ok (the top level uses winc & ~wfull).
- Simultaneous write and reader advance:
  - wbinnext includes the write and wq2_rptr reflects the read, so the level is unchanged.
  - The full flag is re-evaluated against the new values.
- wq2_rptr must change at most one Gray bit per wclk. Multi-bit jumps are illegal stimulus, and the level result is undefined for them.
- Reset mid-operation: all state returns to reset values immediately. The first write after release uses waddr=0.

Decomposition:
- Shared package fifo_pkg holds:
  - function bin2gray(bin) and function gray2bin(gray), both parameterized by width via ADDRSIZE+1.
  - localparam DEPTH = 2**ADDRSIZE, for reuse by the read side and the bench.
- No sub-module: the gray-to-binary is a single function call. The block is one module with three always_ff processes: pointers, flags/level, overflow.

Test Plan (ADDRSIZE=4, AFULL_THRESH=14):
- Reset, all inputs 0 -> wptr=0, waddr=0, wfull=0, wafull=0, wlevel=0, wovf=0. Asserting wrst_n low with no wclk while wfull=1 clears everything immediately.
- wq2_rptr=0, 16 consecutive winc:
  - wlevel counts 1..16.
  - wafull=1 after the 14th write.
  - wfull=1 after the 16th write, with wptr=5'b11000 and waddr=0.
- While full, winc=1 for 3 cycles -> wptr/waddr/wlevel unchanged and wovf=1. wovf_clr=1 with winc=0 -> wovf=0. wovf_clr=1 with winc=1 while full -> wovf stays 1.
- While full, set wq2_rptr=5'b00001 (gray 1):
  - Next edge: wfull=0, wlevel=15, wafull=1.
  - One more winc: wfull=1, wptr=5'b11001 (gray 17), waddr=1.
- Same-cycle winc=1 and a wq2_rptr advance at level 10 -> wlevel stays 10 and wfull stays 0.
- Wrap-around: 40 writes with wq2_rptr tracking the write pointer 2 edges late (one Gray bit per clock):
  - wbin wraps 31->0, and wptr returns to 0 after 32 writes.
  - wlevel never exceeds 2 and wfull never asserts.
